// File: rtl/scope_str_serializer.sv
// scope_str_serializer
//   Takes one packed, MSB-first, NUL-padded scope string per load handshake.
//   It strips the leading NUL padding and streams the remaining bytes one per
//   beat over a valid/ready link.
//
// Optional feature (compile-time macro SCOPE_SER_NEWLINE_EN):
//   When the macro is defined, a trailing 8'h0a beat is appended and carries
//   out_last. An all-NUL string then emits only that beat. When the macro is
//   undefined, out_last marks the final string byte, and an all-NUL string
//   pulses empty_drop instead of emitting any beat.
//
// Ports:
//   clk         single clock, posedge
//   reset_l     synchronous active-low reset
//   load_valid  producer offers load_str
//   load_ready  high only while idle
//   load_str    NCHARS*8-bit packed string, first character in the top byte
//   out_valid   out_char holds a beat
//   out_ready   sink accepts the beat
//   out_char    character byte
//   out_last    final beat of the current string
//   empty_drop  one-cycle pulse: the loaded string produced no beats
module scope_str_serializer #(
   parameter int unsigned NCHARS = 100
) (
   input  logic                clk,
   input  logic                reset_l,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [NCHARS*8-1:0] load_str,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_char,
   output logic                out_last,
   output logic                empty_drop
);

   localparam int unsigned SW = NCHARS * 8;

`ifdef SCOPE_SER_NEWLINE_EN
   localparam bit NL_EN = 1'b1;
`else
   localparam bit NL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SKIP,
      S_SEND
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] buf_q, buf_d;
   logic [7:0]    idx_q, idx_d;
   logic          load_ready_d;
   logic          out_valid_d;
   logic [7:0]    out_char_d;
   logic          out_last_d;
   logic          empty_drop_d;

   // buf_q is shifted left by one byte per idx decrement.
   // Its top byte is therefore always byte idx of the captured string.
   logic [7:0] head_c;
   logic [7:0] next_c;
   assign head_c = buf_q[SW-1 -: 8];
   assign next_c = buf_q[SW-9 -: 8];

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         idx_q      <= 8'h00;
         load_ready <= 1'b1;
         out_valid  <= 1'b0;
         out_char   <= 8'h00;
         out_last   <= 1'b0;
         empty_drop <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         load_ready <= load_ready_d;
         out_valid  <= out_valid_d;
         out_char   <= out_char_d;
         out_last   <= out_last_d;
         empty_drop <= empty_drop_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      idx_d        = idx_q;
      out_valid_d  = out_valid;
      out_char_d   = out_char;
      out_last_d   = out_last;
      empty_drop_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (load_valid && load_ready) begin
               buf_d   = load_str;
               idx_d   = 8'(NCHARS - 1);
               state_d = S_SKIP;
            end
         end

         S_SKIP: begin
            if (head_c != 8'h00) begin
               out_valid_d = 1'b1;
               out_char_d  = head_c;
               out_last_d  = !NL_EN && (idx_q == 8'd0);
               state_d     = S_SEND;
            end else if (idx_q != 8'd0) begin
               idx_d = idx_q - 8'd1;
               buf_d = buf_q << 8;
            end else if (NL_EN) begin
               // Empty string still yields the lone newline beat.
               out_valid_d = 1'b1;
               out_char_d  = 8'h0a;
               out_last_d  = 1'b1;
               state_d     = S_SEND;
            end else begin
               empty_drop_d = 1'b1;
               state_d      = S_IDLE;
            end
         end

         S_SEND: begin
            if (out_valid && out_ready) begin
               if (out_last) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = S_IDLE;
               end else if (idx_q != 8'd0) begin
                  idx_d      = idx_q - 8'd1;
                  buf_d      = buf_q << 8;
                  out_char_d = next_c;
                  out_last_d = !NL_EN && (idx_q == 8'd1);
               end else begin
                  // Only reachable with the newline beat enabled.
                  out_char_d = 8'h0a;
                  out_last_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      load_ready_d = (state_d == S_IDLE);
   end

endmodule

// File: doc/scope_str_serializer.md
# scope_str_serializer

Downstream consumer of hierarchical scope strings (e.g. a `tag` instance's `%m`-formatted `bit [NCHARS*8-1:0] scope`). It captures one packed, MSB-first, NUL-padded string per load handshake. It drops the leading NUL padding, matching `%0s` semantics, then streams the remaining characters one byte per beat over a valid/ready interface. It sits between scope-tag producers and a character sink (log FIFO / UART model) in the regression benches.

## Interface
- `NCHARS`, 100: string capacity in bytes; the load bus is `NCHARS*8` bits; legal range 2..255.
- `clk`  in  1  single clock; all logic on posedge.
- `reset_l`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `load_valid`  in  1  producer offers `load_str`.
- `load_ready`  out  1  high only in IDLE.
- `load_str`  in  NCHARS*8  packed string; byte `[NCHARS*8-1 -: 8]` is the first character.
- `out_valid`  out  1  `out_char` holds a beat.
- `out_ready`  in  1  sink accepts the beat.
- `out_char`  out  8  character byte.
- `out_last`  out  1  final beat of the current string.
- `empty_drop`  out  1  one-cycle pulse: the loaded string produced no beats.

## Operation
- **States:** IDLE, SKIP, SEND.
- **Registers:**
  - `buf` holds NCHARS bytes.
  - `idx` is 8 bits, the byte index; `NCHARS-1` is the first character.
- **IDLE**
  - `load_ready=1`.
  - On `load_valid && load_ready`: capture `load_str` into `buf`, set `idx=NCHARS-1`, go to SKIP.
- **SKIP** (one byte examined per cycle)
  - `buf[idx]!=0`: load `out_char=buf[idx]`, assert `out_valid`, go to SEND.
  - `buf[idx]==0 && idx!=0`: `idx--`.
  - `buf[idx]==0 && idx==0`: the string is empty; handle per Configuration.
- **SEND**
  - `out_char` and `out_last` hold stable while `out_valid && !out_ready`.
  - On a transfer (`out_valid && out_ready`):
    - If `out_last`: deassert `out_valid`, go to IDLE.
    - Otherwise: `idx--`, present `buf[idx-1]` on the next cycle.
  - Throughput is one beat per cycle with `out_ready` held high.
- **Embedded NULs:** once the first non-NUL byte has been found, later NUL bytes are sent unchanged. Only leading padding is stripped.
- **`out_last`:** set on the `idx==0` beat, or on the newline beat when that feature is enabled.
- **Byte arithmetic:** `idx` never underflows. The `idx==0` check always precedes the decrement.
- **Input sampling:** `load_str` is sampled only in the capture cycle; changes afterwards are ignored.
- **Reset values** (also applied on reset mid-string; the partial string is discarded and no further beat is issued):
  - state IDLE, `load_ready=1`
  - `out_valid=0`, `out_char=8'h00`, `out_last=0`
  - `empty_drop=0`, `idx=0`, `buf=0`

## Timing
- Load accepted at cycle T; SKIP runs from T+1.
- With L leading NUL bytes (L<NCHARS), the first `out_valid` is registered high at T+2+L.
- A string of N non-padding bytes (N≥1), with `out_ready` held high:
  - last beat at T+1+L+N;
  - `load_ready` high again at T+2+L+N.
- An all-NUL string: `empty_drop` pulses at T+1+NCHARS; IDLE at T+1+NCHARS.
- `load_valid` during SKIP or SEND is ignored (`load_ready=0`); the producer must hold it.
- Reset asserted and `out_ready` high in the same cycle: reset wins; the beat is not counted as transferred.

## Configuration
- `SCOPE_SER_NEWLINE_EN` defined:
  - After the final string byte, one extra beat `out_char=8'h0a` is sent, with `out_last=1` on that beat only.
  - An all-NUL string emits the single `8'h0a` beat; `empty_drop` stays 0.
- Undefined:
  - `out_last` is set on the final string byte.
  - An all-NUL string emits nothing and pulses `empty_drop`.

## Test plan
- Load `"top.t.tag"` (L=91), `out_ready=1` -> first beat `8'h74` at T+93, 9 beats `top.t.tag`, `out_last` on `8'h67`; with the macro, a 10th beat `8'h0a` carries `out_last`.
- Load `"top.t.b.gen[1].tag"` and toggle `out_ready` 0/1 every cycle -> 18 beats in order; `out_char` stable during every stall.
- Load all-NUL -> macro off: `empty_drop` pulse at T+101, no `out_valid`; macro on: one `8'h0a` beat with `out_last`.
- Load a full 100-char string with no padding -> first beat at T+2, 100 beats, `out_last` on beat 100, `load_ready` at T+102.
- Drive `reset_l=0` during beat 4 of `"top.t.b"` -> next cycle `out_valid=0` and `load_ready=1`; the following load streams cleanly from its first character.
- Load `"a\0b"` (embedded NUL) -> 3 beats: `8'h61`, `8'h00`, `8'h62`.
